// File: rtl/ads868x_spi_responder_pkg.sv
// Shared encodings for the ADS868x SPI responder: command codes, register map,
// power/mode states and the auto-sequence channel helpers.
package ads868x_spi_responder_pkg;

  typedef enum logic [1:0] {
    PWR_ACTIVE = 2'd0,
    PWR_STDBY  = 2'd1,
    PWR_PD     = 2'd2
  } pwr_e;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  localparam logic [15:0] CMD_NO_OP    = 16'h0000;
  localparam logic [15:0] CMD_STDBY    = 16'h8200;
  localparam logic [15:0] CMD_PWR_DN   = 16'h8300;
  localparam logic [15:0] CMD_RST      = 16'h8500;
  localparam logic [15:0] CMD_AUTO_RST = 16'hA000;
  localparam logic [2:0]  CMD_MAN_PFX  = 3'b110;

  localparam logic [6:0] ADDR_AUTO_SEQ_EN = 7'h01;
  localparam logic [6:0] ADDR_CH_PWR_DN   = 7'h02;
  localparam logic [6:0] ADDR_FEATURE     = 7'h03;
  localparam logic [6:0] ADDR_RANGE_LO    = 7'h05;
  localparam logic [6:0] ADDR_RANGE_HI    = 7'h0C;

  localparam logic [7:0] DEF_AUTO_SEQ_EN = 8'hFF;
  localparam logic [7:0] DEF_CH_PWR_DN   = 8'h00;
  localparam logic [7:0] DEF_FEATURE     = 8'h00;
  localparam logic [7:0] DEF_RANGE       = 8'h00;

  // Next enabled channel after cur, wrapping 7->0; an empty mask holds cur.
  function automatic logic [2:0] next_enabled_ch(input logic [2:0] cur, input logic [7:0] en);
    logic [2:0] idx;
    logic       found;
    next_enabled_ch = cur;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = cur + 3'(i);
      if (!found && en[idx]) begin
        next_enabled_ch = idx;
        found = 1'b1;
      end
    end
  endfunction

  function automatic logic [2:0] lowest_enabled_ch(input logic [2:0] cur, input logic [7:0] en);
    lowest_enabled_ch = cur;
    for (int i = 7; i >= 0; i--) begin
      if (en[i]) lowest_enabled_ch = 3'(i);
    end
  endfunction

endpackage

// File: rtl/ads868x_spi_responder_frontend.sv
// Pin front end: synchronizers, SCK/SS edge strobes, device-reset merge and
// the saturating falling-edge bit counter.
module ads868x_spi_responder_frontend #(
  parameter int C_SYNC_STAGES = 2
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       i_sck,
  input  logic       i_ss_n,
  input  logic       i_mosi,
  input  logic       i_rst_pd_n,
  output logic       o_rst,
  output logic       o_sck_rise,
  output logic       o_sck_fall,
  output logic       o_ss_fall,
  output logic       o_ss_rise,
  output logic       o_mosi,
  output logic [5:0] o_bitcnt
);

  logic [C_SYNC_STAGES-1:0] r_sck_sync;
  logic [C_SYNC_STAGES-1:0] r_ss_sync;
  logic [C_SYNC_STAGES-1:0] r_mosi_sync;
  logic [C_SYNC_STAGES-1:0] r_rstpd_sync;
  logic                     r_sck_d;
  logic                     r_ss_d;
  logic [5:0]               r_bitcnt;
  logic                     w_sck;
  logic                     w_ss_n;

  always_ff @(posedge aclk) begin
    r_sck_sync  <= {r_sck_sync[C_SYNC_STAGES-2:0], i_sck};
    r_ss_sync   <= {r_ss_sync[C_SYNC_STAGES-2:0], i_ss_n};
    r_mosi_sync <= {r_mosi_sync[C_SYNC_STAGES-2:0], i_mosi};
    r_sck_d     <= w_sck;
    r_ss_d      <= w_ss_n;
  end

  // areset clears the pin chain so the device stays in reset until the pin is seen high again.
  always_ff @(posedge aclk) begin
    if (areset) r_rstpd_sync <= '0;
    else        r_rstpd_sync <= {r_rstpd_sync[C_SYNC_STAGES-2:0], i_rst_pd_n};
  end

  assign w_sck      = r_sck_sync[C_SYNC_STAGES-1];
  assign w_ss_n     = r_ss_sync[C_SYNC_STAGES-1];
  assign o_rst      = areset | ~r_rstpd_sync[C_SYNC_STAGES-1];
  assign o_sck_rise = ~w_ss_n &  w_sck & ~r_sck_d;
  assign o_sck_fall = ~w_ss_n & ~w_sck &  r_sck_d;
  assign o_ss_fall  = ~w_ss_n &  r_ss_d;
  assign o_ss_rise  =  w_ss_n & ~r_ss_d;
  assign o_mosi     = r_mosi_sync[C_SYNC_STAGES-1];
  assign o_bitcnt   = r_bitcnt;

  always_ff @(posedge aclk) begin
    if (o_rst)                                r_bitcnt <= 6'd0;
    else if (o_ss_fall)                       r_bitcnt <= 6'd0;
    else if (o_sck_fall && r_bitcnt != 6'd63) r_bitcnt <= r_bitcnt + 6'd1;
  end

endmodule

// File: rtl/ads868x_spi_responder.sv
// ADS868x device model: decodes 32-SCLK frames, holds the program registers and
// channel/power state, and returns samples from an AXI-Stream-loaded bank.
module ads868x_spi_responder
  import ads868x_spi_responder_pkg::*;
#(
  parameter int C_SYNC_STAGES = 2
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        SCK_I,
  input  logic        SS_I,
  input  logic        MOSI_I,
  output logic        MISO_O,
  output logic        MISO_T,
  input  logic        RST_PD_N,
  input  logic [18:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic        frame_done,
  output logic [15:0] frame_cmd,
  output logic [2:0]  cur_ch
);

  logic        w_rst;
  logic        w_sck_rise;
  logic        w_sck_fall;
  logic        w_ss_fall;
  logic        w_ss_rise;
  logic        w_mosi;
  logic [5:0]  w_bitcnt;

  logic [15:0] r_cmd_sh;
  logic [15:0] r_conv;
  logic [15:0] r_tx_sh;
  logic [15:0] r_bank [8];
  logic [7:0]  r_seq_en;
  logic [7:0]  r_ch_pd;
  logic [7:0]  r_feature;
  logic [7:0]  r_range [8];
  pwr_e        r_pwr;
  mode_e       r_mode;
  logic [2:0]  r_cur_ch;
  logic        r_rd_pend;
  logic [7:0]  r_rd_data;
  logic        r_tready;

  logic        w_decode;
  logic [6:0]  w_addr;
  logic [2:0]  w_range_idx;
  logic        w_range_hit;
  logic [7:0]  w_rd_val;
  logic [15:0] w_tx_word;
  pwr_e        w_nx_pwr;
  mode_e       w_nx_mode;
  logic [2:0]  w_nx_ch;
  logic        w_regs_dflt;
  logic        w_reg_wr;
  logic        w_reg_rd;

  ads868x_spi_responder_frontend #(
    .C_SYNC_STAGES(C_SYNC_STAGES)
  ) u_frontend (
    .aclk       (aclk),
    .areset     (areset),
    .i_sck      (SCK_I),
    .i_ss_n     (SS_I),
    .i_mosi     (MOSI_I),
    .i_rst_pd_n (RST_PD_N),
    .o_rst      (w_rst),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall),
    .o_ss_fall  (w_ss_fall),
    .o_ss_rise  (w_ss_rise),
    .o_mosi     (w_mosi),
    .o_bitcnt   (w_bitcnt)
  );

  assign w_decode      = w_ss_rise && (w_bitcnt >= 6'd32);
  assign w_addr        = r_cmd_sh[15:9];
  assign w_range_idx   = r_cmd_sh[11:9] - 3'd5;
  assign w_range_hit   = (w_addr >= ADDR_RANGE_LO) && (w_addr <= ADDR_RANGE_HI);
  assign w_tx_word     = r_rd_pend ? {r_rd_data, 8'h00} : r_conv;
  assign s_axis_tready = r_tready;
  assign cur_ch        = r_cur_ch;

  always_comb begin
    w_rd_val = 8'h00;
    case (w_addr)
      ADDR_AUTO_SEQ_EN: w_rd_val = r_seq_en;
      ADDR_CH_PWR_DN:   w_rd_val = r_ch_pd;
      ADDR_FEATURE:     w_rd_val = r_feature;
      default:          if (w_range_hit) w_rd_val = r_range[w_range_idx];
    endcase
  end

  // Fixed command codes take priority over the generic register read/write forms.
  always_comb begin
    w_nx_pwr    = r_pwr;
    w_nx_mode   = r_mode;
    w_nx_ch     = r_cur_ch;
    w_regs_dflt = 1'b0;
    w_reg_wr    = 1'b0;
    w_reg_rd    = 1'b0;
    if (r_cmd_sh == CMD_NO_OP) begin
      if (r_mode == MODE_AUTO) w_nx_ch = next_enabled_ch(r_cur_ch, r_seq_en);
    end else if (r_cmd_sh == CMD_STDBY) begin
      w_nx_pwr = PWR_STDBY;
    end else if (r_cmd_sh == CMD_PWR_DN) begin
      w_nx_pwr = PWR_PD;
    end else if (r_cmd_sh == CMD_RST) begin
      w_regs_dflt = 1'b1;
      w_nx_pwr    = PWR_ACTIVE;
      w_nx_mode   = MODE_MANUAL;
    end else if (r_cmd_sh == CMD_AUTO_RST) begin
      w_nx_pwr  = PWR_ACTIVE;
      w_nx_mode = MODE_AUTO;
      w_nx_ch   = lowest_enabled_ch(r_cur_ch, r_seq_en);
    end else if (r_cmd_sh[15:13] == CMD_MAN_PFX && r_cmd_sh[9:0] == 10'd0) begin
      w_nx_pwr  = PWR_ACTIVE;
      w_nx_mode = MODE_MANUAL;
      w_nx_ch   = r_cmd_sh[12:10];
    end else if (r_cmd_sh[8]) begin
      w_reg_wr = 1'b1;
    end else begin
      w_reg_rd = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (w_rst) begin
      r_pwr      <= PWR_ACTIVE;
      r_mode     <= MODE_MANUAL;
      r_cur_ch   <= 3'd0;
      r_rd_pend  <= 1'b0;
      r_seq_en   <= DEF_AUTO_SEQ_EN;
      r_ch_pd    <= DEF_CH_PWR_DN;
      r_feature  <= DEF_FEATURE;
      for (int i = 0; i < 8; i++) r_range[i] <= DEF_RANGE;
      frame_done <= 1'b0;
      frame_cmd  <= 16'h0000;
      r_tready   <= 1'b0;
    end else begin
      r_tready   <= 1'b1;
      frame_done <= w_decode;
      if (w_decode) begin
        frame_cmd <= r_cmd_sh;
        r_pwr     <= w_nx_pwr;
        r_mode    <= w_nx_mode;
        r_cur_ch  <= w_nx_ch;
        r_rd_pend <= w_reg_rd;
        if (w_regs_dflt) begin
          r_seq_en  <= DEF_AUTO_SEQ_EN;
          r_ch_pd   <= DEF_CH_PWR_DN;
          r_feature <= DEF_FEATURE;
          for (int i = 0; i < 8; i++) r_range[i] <= DEF_RANGE;
        end else if (w_reg_wr) begin
          case (w_addr)
            ADDR_AUTO_SEQ_EN: r_seq_en  <= r_cmd_sh[7:0];
            ADDR_CH_PWR_DN:   r_ch_pd   <= r_cmd_sh[7:0];
            ADDR_FEATURE:     r_feature <= r_cmd_sh[7:0];
            default:          if (w_range_hit) r_range[w_range_idx] <= r_cmd_sh[7:0];
          endcase
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (w_reg_rd && w_decode) r_rd_data <= w_rd_val;
    if (w_sck_fall && w_bitcnt < 6'd16) r_cmd_sh <= {r_cmd_sh[14:0], w_mosi};
    // Snapshot at SS fall so a bank write later in the frame cannot disturb it.
    if (w_ss_fall) begin
      if (r_pwr != PWR_ACTIVE || r_ch_pd[r_cur_ch]) r_conv <= 16'h0000;
      else                                          r_conv <= r_bank[r_cur_ch];
    end
  end

  always_ff @(posedge aclk) begin
    if (w_rst) begin
      for (int i = 0; i < 8; i++) r_bank[i] <= 16'h0000;
    end else if (s_axis_tvalid && r_tready) begin
      r_bank[s_axis_tdata[18:16]] <= s_axis_tdata[15:0];
    end
  end

  // Rising edge N (bitcnt = N-1) drives data bit N+1; bits 17..32 come from w_tx_word.
  always_ff @(posedge aclk) begin
    if (w_rst) begin
      MISO_O <= 1'b0;
      MISO_T <= 1'b1;
    end else if (w_ss_fall) begin
      MISO_O <= 1'b0;
      MISO_T <= 1'b0;
    end else if (w_ss_rise) begin
      MISO_O <= 1'b0;
      MISO_T <= 1'b1;
    end else if (w_sck_rise) begin
      if (w_bitcnt == 6'd15) begin
        MISO_O  <= w_tx_word[15];
        r_tx_sh <= {w_tx_word[14:0], 1'b0};
      end else if (w_bitcnt >= 6'd16 && w_bitcnt <= 6'd30) begin
        MISO_O  <= r_tx_sh[15];
        r_tx_sh <= {r_tx_sh[14:0], 1'b0};
      end else begin
        MISO_O <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ads868x_spi_responder.sv
// Directed bench for the ADS868x responder: drives SPI frames bit by bit and
// checks returned data, channel state and frame strobes against hand values.
module tb_ads868x_spi_responder;

  logic        aclk = 1'b0;
  logic        areset;
  logic        SCK_I;
  logic        SS_I;
  logic        MOSI_I;
  logic        MISO_O;
  logic        MISO_T;
  logic        RST_PD_N;
  logic [18:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        frame_done;
  logic [15:0] frame_cmd;
  logic [2:0]  cur_ch;

  int          n_vec = 0;
  int          n_err = 0;
  int          fd_cnt = 0;
  int          exp_fd = 0;
  logic        tri_mid;
  logic        mid_wr_en = 1'b0;
  logic [18:0] mid_wr = 19'd0;
  logic [15:0] d;

  ads868x_spi_responder #(.C_SYNC_STAGES(2)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .SCK_I         (SCK_I),
    .SS_I          (SS_I),
    .MOSI_I        (MOSI_I),
    .MISO_O        (MISO_O),
    .MISO_T        (MISO_T),
    .RST_PD_N      (RST_PD_N),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .frame_done    (frame_done),
    .frame_cmd     (frame_cmd),
    .cur_ch        (cur_ch)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

  task automatic cyc(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic bank_wr(input logic [2:0] ch, input logic [15:0] v);
    s_axis_tdata  = {ch, v};
    s_axis_tvalid = 1'b1;
    cyc(1);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic spi_bit(input logic mosi, output logic miso);
    MOSI_I = mosi;
    cyc(4);
    SCK_I = 1'b1;
    cyc(6);
    miso = MISO_O;
    SCK_I = 1'b0;
    cyc(6);
  endtask

  task automatic spi_frame(input logic [15:0] cmd, input int nbits, output logic [15:0] dout);
    logic m;
    dout = 16'h0000;
    SS_I = 1'b0;
    cyc(6);
    tri_mid = MISO_T;
    for (int b = 1; b <= nbits; b++) begin
      spi_bit((b <= 16) ? cmd[16-b] : 1'b0, m);
      if (b >= 16 && b <= 31) dout[31-b] = m;
      if (b == 8 && mid_wr_en) bank_wr(mid_wr[18:16], mid_wr[15:0]);
    end
    cyc(4);
    SS_I = 1'b1;
    cyc(8);
    if (nbits >= 32) exp_fd++;
  endtask

  task automatic test_reset;
    areset = 1'b1; RST_PD_N = 1'b1; SS_I = 1'b1; SCK_I = 1'b0; MOSI_I = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    cyc(6);
    n_vec++; if (MISO_T !== 1'b1) begin n_err++; $display("FAIL rst_miso_t: got %b want 1", MISO_T); end
    n_vec++; if (MISO_O !== 1'b0) begin n_err++; $display("FAIL rst_miso_o: got %b want 0", MISO_O); end
    n_vec++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL rst_tready: got %b want 0", s_axis_tready); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
    n_vec++; if (frame_cmd !== 16'h0000) begin n_err++; $display("FAIL rst_frame_cmd: got %h want 0000", frame_cmd); end
    n_vec++; if (cur_ch !== 3'd0) begin n_err++; $display("FAIL rst_cur_ch: got %0d want 0", cur_ch); end
    areset = 1'b0;
    cyc(6);
    n_vec++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL tready_run: got %b want 1", s_axis_tready); end
    bank_wr(3'd0, 16'hA0A0);
    bank_wr(3'd1, 16'h1234);
    bank_wr(3'd2, 16'h2C2C);
    bank_wr(3'd3, 16'hBEEF);
    cyc(2);
  endtask

  task automatic test_manual;
    spi_frame(16'hCC00, 32, d);
    n_vec++; if (d !== 16'hA0A0) begin n_err++; $display("FAIL man_data0: got %h want A0A0", d); end
    n_vec++; if (tri_mid !== 1'b0) begin n_err++; $display("FAIL man_tri_mid: got %b want 0", tri_mid); end
    n_vec++; if (MISO_T !== 1'b1) begin n_err++; $display("FAIL man_tri_end: got %b want 1", MISO_T); end
    n_vec++; if (frame_cmd !== 16'hCC00) begin n_err++; $display("FAIL man_cmd: got %h want CC00", frame_cmd); end
    n_vec++; if (cur_ch !== 3'd3) begin n_err++; $display("FAIL man_ch: got %0d want 3", cur_ch); end
    n_vec++; if (fd_cnt !== exp_fd) begin n_err++; $display("FAIL man_fd: got %0d want %0d", fd_cnt, exp_fd); end
    spi_frame(16'h0000, 32, d);
    n_vec++; if (d !== 16'hBEEF) begin n_err++; $display("FAIL man_data3: got %h want BEEF", d); end
    n_vec++; if (cur_ch !== 3'd3) begin n_err++; $display("FAIL man_nop_hold: got %0d want 3", cur_ch); end
  endtask

  task automatic test_auto;
    logic [15:0] exp_d [3] = '{16'hA0A0, 16'h2C2C, 16'hA0A0};
    logic [2:0]  exp_c [3] = '{3'd2, 3'd0, 3'd2};
    spi_frame(16'h0305, 32, d);
    spi_frame(16'hA000, 32, d);
    n_vec++; if (d !== 16'hBEEF) begin n_err++; $display("FAIL auto_rst_data: got %h want BEEF", d); end
    n_vec++; if (cur_ch !== 3'd0) begin n_err++; $display("FAIL auto_rst_ch: got %0d want 0", cur_ch); end
    for (int i = 0; i < 3; i++) begin
      spi_frame(16'h0000, 32, d);
      n_vec++; if (d !== exp_d[i]) begin n_err++; $display("FAIL auto_data%0d: got %h want %h", i, d, exp_d[i]); end
      n_vec++; if (cur_ch !== exp_c[i]) begin n_err++; $display("FAIL auto_ch%0d: got %0d want %0d", i, cur_ch, exp_c[i]); end
    end
  endtask

  task automatic test_read;
    spi_frame(16'h0400, 32, d);
    n_vec++; if (cur_ch !== 3'd2) begin n_err++; $display("FAIL rd_ch_hold: got %0d want 2", cur_ch); end
    spi_frame(16'h0000, 32, d);
    n_vec++; if (d !== 16'h0000) begin n_err++; $display("FAIL rd_ch_pwr_dn: got %h want 0000", d); end
    n_vec++; if (cur_ch !== 3'd0) begin n_err++; $display("FAIL rd_nop_adv: got %0d want 0", cur_ch); end
    spi_frame(16'h0200, 32, d);
    n_vec++; if (d !== 16'hA0A0) begin n_err++; $display("FAIL rd_frame_data: got %h want A0A0", d); end
    spi_frame(16'h0000, 32, d);
    n_vec++; if (d !== 16'h0500) begin n_err++; $display("FAIL rd_seq_en: got %h want 0500", d); end
    n_vec++; if (cur_ch !== 3'd2) begin n_err++; $display("FAIL rd_ch2: got %0d want 2", cur_ch); end
  endtask

  task automatic test_power;
    spi_frame(16'h8300, 32, d);
    n_vec++; if (d !== 16'h2C2C) begin n_err++; $display("FAIL pd_frame_data: got %h want 2C2C", d); end
    spi_frame(16'h0000, 32, d);
    n_vec++; if (d !== 16'h0000) begin n_err++; $display("FAIL pd_data: got %h want 0000", d); end
    spi_frame(16'hC400, 32, d);
    n_vec++; if (cur_ch !== 3'd1) begin n_err++; $display("FAIL pd_man_ch: got %0d want 1", cur_ch); end
    spi_frame(16'h0502, 32, d);
    n_vec++; if (d !== 16'h1234) begin n_err++; $display("FAIL pd_wake_data: got %h want 1234", d); end
    spi_frame(16'h0500, 32, d);
    n_vec++; if (d !== 16'h0000) begin n_err++; $display("FAIL ch_pwr_dn_data: got %h want 0000", d); end
    spi_frame(16'h0000, 32, d);
    n_vec++; if (d !== 16'h1234) begin n_err++; $display("FAIL ch_pwr_up_data: got %h want 1234", d); end
  endtask

  task automatic test_bank_midframe;
    mid_wr = {3'd1, 16'h5555};
    mid_wr_en = 1'b1;
    spi_frame(16'h0000, 32, d);
    mid_wr_en = 1'b0;
    n_vec++; if (d !== 16'h1234) begin n_err++; $display("FAIL mid_wr_old: got %h want 1234", d); end
    spi_frame(16'h0000, 32, d);
    n_vec++; if (d !== 16'h5555) begin n_err++; $display("FAIL mid_wr_new: got %h want 5555", d); end
  endtask

  task automatic test_abort;
    spi_frame(16'hC000, 10, d);
    n_vec++; if (fd_cnt !== exp_fd) begin n_err++; $display("FAIL abort_fd: got %0d want %0d", fd_cnt, exp_fd); end
    n_vec++; if (frame_cmd !== 16'h0000) begin n_err++; $display("FAIL abort_cmd: got %h want 0000", frame_cmd); end
    n_vec++; if (cur_ch !== 3'd1) begin n_err++; $display("FAIL abort_ch: got %0d want 1", cur_ch); end
    spi_frame(16'hC800, 32, d);
    n_vec++; if (d !== 16'h5555) begin n_err++; $display("FAIL post_abort_data: got %h want 5555", d); end
    n_vec++; if (fd_cnt !== exp_fd) begin n_err++; $display("FAIL post_abort_fd: got %0d want %0d", fd_cnt, exp_fd); end
    n_vec++; if (frame_cmd !== 16'hC800) begin n_err++; $display("FAIL post_abort_cmd: got %h want C800", frame_cmd); end
    n_vec++; if (cur_ch !== 3'd2) begin n_err++; $display("FAIL post_abort_ch: got %0d want 2", cur_ch); end
  endtask

  task automatic test_reset_midframe(input bit use_pin);
    logic m;
    spi_frame(16'h0333, 32, d);
    SS_I = 1'b0;
    cyc(6);
    for (int b = 0; b < 5; b++) spi_bit(1'b1, m);
    if (use_pin) RST_PD_N = 1'b0; else areset = 1'b1;
    cyc(6);
    n_vec++; if (MISO_T !== 1'b1) begin n_err++; $display("FAIL midrst_tri pin=%0d: got %b want 1", use_pin, MISO_T); end
    n_vec++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL midrst_tready pin=%0d: got %b want 0", use_pin, s_axis_tready); end
    n_vec++; if (cur_ch !== 3'd0) begin n_err++; $display("FAIL midrst_ch pin=%0d: got %0d want 0", use_pin, cur_ch); end
    RST_PD_N = 1'b1;
    areset = 1'b0;
    cyc(8);
    SS_I = 1'b1;
    cyc(8);
    n_vec++; if (fd_cnt !== exp_fd) begin n_err++; $display("FAIL midrst_fd pin=%0d: got %0d want %0d", use_pin, fd_cnt, exp_fd); end
    spi_frame(16'h0200, 32, d);
    n_vec++; if (d !== 16'h0000) begin n_err++; $display("FAIL midrst_bank pin=%0d: got %h want 0000", use_pin, d); end
    spi_frame(16'h0000, 32, d);
    n_vec++; if (d !== 16'hFF00) begin n_err++; $display("FAIL midrst_seq_en pin=%0d: got %h want FF00", use_pin, d); end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_auto();
    test_read();
    test_power();
    test_bank_midframe();
    test_abort();
    test_reset_midframe(1'b0);
    test_reset_midframe(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
